dac_sample_feeder: RTL and testbench
====================================

# dac_sample_feeder

Upstream companion of the DAC SPI controller: buffers 16-bit samples from the host side in a small FIFO and releases them to the controller at a programmed sample rate. Each release updates the controller's data word and pulses its `renew` input. The sample period is clamped to a minimum so a new transfer never starts before the previous SPI frame and LDAC sequence have finished. Underrun and overflow are reported as sticky flags.

## Interface
Parameters:
- `DATA_W` = 16 — sample width; matches the controller's `data_i`.
- `DEPTH_LOG2` = 4 — FIFO depth is 2^DEPTH_LOG2 = 16 entries.
- `PERIOD_W` = 16 — width of the `period` input.
- `MIN_PERIOD` = 128 — lower clamp on the effective period, in clk cycles; must exceed one full controller transaction.

Ports:
- `clk` in 1 — system clock; single clock domain.
- `rst` in 1 — asynchronous, active-high reset.
- `en` in 1 — streaming enable.
- `period` in PERIOD_W — sample period in clk cycles.
- `wr_en` in 1 — push `wr_data` into the FIFO.
- `wr_data` in DATA_W — sample to push.
- `flush` in 1 — empty the FIFO and restart the timer.
- `clr_flags` in 1 — clear `underrun` and `overflow`.
- `full` out 1 — FIFO holds 2^DEPTH_LOG2 entries.
- `empty` out 1 — FIFO holds 0 entries.
- `level` out DEPTH_LOG2+1 — current FIFO occupancy.
- `data_o` out DATA_W — connects to the controller's `data_i`.
- `dac_en_o` out 1 — connects to the controller's `dac_en`.
- `renew_o` out 1 — connects to the controller's `renew`; one-cycle pulse.
- `underrun` out 1 — sticky: a tick occurred while the FIFO was empty.
- `overflow` out 1 — sticky: a write was attempted while the FIFO was full.

## Operation
**Reset values**
- `data_o`=0, `renew_o`=0, `dac_en_o`=0, `level`=0, `full`=0, `empty`=1, `underrun`=0, `overflow`=0.
- Pointers and tick counter = 0.

**FIFO**
- Circular buffer with DEPTH_LOG2-bit read/write pointers; pointers wrap modulo depth.
- `level` is an up/down counter; `full` and `empty` are decoded from `level`.
- A write is accepted when `wr_en` is high and `full` is low, where `full` is the value at the start of the cycle. This holds even if a pop occurs in the same cycle.
- A write while full is dropped and sets `overflow`.
- Write and pop in the same cycle: `level` is unchanged; both pointers advance.

**Effective period and tick**
- `eff = (period < MIN_PERIOD) ? MIN_PERIOD : period`, compared at full PERIOD_W width.
- While `en` is high, the tick counter increments each cycle.
- When `cnt >= eff-1`: a tick is raised and `cnt` returns to 0.
- Using `>=` makes a mid-count decrease of `period` wrap immediately, with no 2^PERIOD_W stall.
- While `en` is low: `cnt` is held at 0, no ticks occur, and FIFO writes are still accepted.

**Tick handling**
- If not empty: pop the head, register it into `data_o`, and assert `renew_o` for exactly 1 cycle, in the same cycle `data_o` changes.
- If empty: `data_o` holds its last value, `renew_o` stays 0, and `underrun` is set.
- A write landing in the same cycle as a tick on an empty FIFO is not popped by that tick. The underrun is still flagged.

**Other controls**
- `dac_en_o` is `en` registered, with one cycle of delay.
- `flush` has priority over write, pop and tick. It zeroes the pointers, `level` and `cnt`; `data_o` and the flags are unchanged; no `renew_o` is issued that cycle.
- `clr_flags` clears both flags. If a set event occurs in the same cycle, the set wins.

## Timing
- `data_o` stays stable from one `renew_o` pulse to the next, at least MIN_PERIOD cycles. The controller samples `data_i` several cycles after `renew`, so this stability is required.
- First release: with `en` rising at cycle 0 and the FIFO non-empty, `renew_o` is high in cycle `eff`. Every subsequent release follows `eff` cycles later.
- Write-to-visible latency: 1 cycle. A sample written in cycle t can be popped by a tick in cycle t+1.
- `en` falling mid-period: the pending tick is discarded; no `renew_o` pulse is issued after `en` is sampled low.
- Asynchronous reset mid-stream: all outputs take their reset values immediately; `renew_o` never glitches high.

## Test plan
- **Basic stream:** reset; write 0x1234, 0xABCD; `period`=200; `en`=1 → `renew_o` pulses at cycles 200 and 400 with `data_o`=0x1234 then 0xABCD; `level` goes 2→1→0.
- **Clamp:** `period`=10, one sample queued → first `renew_o` at cycle 128, not cycle 10.
- **Underrun:** FIFO empty, `en`=1, `period`=150 → no `renew_o`; `underrun`=1 at cycle 150; `data_o` holds its previous value; `clr_flags` → `underrun`=0.
- **Full/overflow:** 17 writes with `en`=0 → `full`=1, `level`=16, `overflow`=1. Then `en`=1 → 16 pops in write order; the 17th value never appears.
- **Simultaneous write+pop at full:** at `level`=16, a write on a tick cycle → write dropped, `overflow` set, `level`=15.
- **Flush/reset mid-operation:** `flush` with 5 entries queued → `level`=0, `empty`=1, `cnt` restarts, `data_o` unchanged. Asserting `rst` mid-period → all outputs at reset values on the same edge, and no `renew_o` after release until `eff` cycles with data.

Source files
------------

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder
// Buffers host samples in a small FIFO and releases one to the DAC SPI
// controller on every sample tick, pulsing renew_o alongside the new data_o.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  streaming enable (registered onto dac_en_o)
//   period              sample period in clk cycles, clamped to MIN_PERIOD
//   wr_en, wr_data      host-side FIFO push
//   flush               empty the FIFO and restart the tick counter
//   clr_flags           clear the sticky underrun/overflow flags
//   full, empty, level  FIFO status
//   data_o, dac_en_o    controller data word and enable
//   renew_o             one-cycle pulse when data_o takes a new sample
//   underrun, overflow  sticky error flags
module dac_sample_feeder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned MIN_PERIOD = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PERIOD_W-1:0]   period,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  flush,
    input  logic                  clr_flags,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DATA_W-1:0]     data_o,
    output logic                  dac_en_o,
    output logic                  renew_o,
    output logic                  underrun,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);
    localparam logic [LVL_W-1:0]    DEPTH_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  renew_q, renew_d;
    logic                  dac_en_q, dac_en_d;
    logic                  underrun_q, underrun_d;
    logic                  overflow_q, overflow_d;

    logic [PERIOD_W-1:0]   eff_c;
    logic                  tick_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  mem_we_c;

    // Next-state logic for FIFO, tick timer, output word and flags
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        renew_d    = 1'b0;
        dac_en_d   = en;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        mem_we_c   = 1'b0;

        eff_c  = (period < MIN_P) ? MIN_P : period;
        // >= lets a shrinking period wrap at once instead of counting to 2^PERIOD_W
        tick_c = en && (cnt_q >= (eff_c - PERIOD_W'(1)));
        // full/empty are start-of-cycle values: a same-cycle pop never makes room
        push_c = wr_en && !full_q;
        pop_c  = tick_c && !empty_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            cnt_d    = '0;
        end else begin
            cnt_d = (!en || tick_c) ? '0 : cnt_q + PERIOD_W'(1);

            if (push_c) begin
                mem_we_c = 1'b1;
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end

            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
                data_d   = mem_q[rd_ptr_q];
                renew_d  = 1'b1;
            end

            if (push_c && !pop_c) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop_c && !push_c) begin
                level_d = level_q - LVL_W'(1);
            end
        end

        // Set beats clear; flush neither sets nor clears the flags itself
        if (clr_flags) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (!flush && tick_c && empty_q) begin
            underrun_d = 1'b1;
        end
        if (!flush && wr_en && full_q) begin
            overflow_d = 1'b1;
        end

        full_d  = (level_d == DEPTH_LVL);
        empty_d = (level_d == '0);
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            cnt_q      <= '0;
            data_q     <= '0;
            renew_q    <= 1'b0;
            dac_en_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            renew_q    <= renew_d;
            dac_en_q   <= dac_en_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign data_o   = data_q;
    assign dac_en_o = dac_en_q;
    assign renew_o  = renew_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Testbench for dac_sample_feeder: directed scenarios plus a randomized
// phase, checked against a queue-based reference model and a release
// scoreboard.
module tb_dac_sample_feeder;

    localparam int MINP = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] period = 16'd0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'd0;
    logic        flush = 1'b0;
    logic        clr_flags = 1'b0;
    logic        full, empty, dac_en_o, renew_o, underrun, overflow;
    logic [4:0]  level;
    logic [15:0] data_o;

    dac_sample_feeder dut (
        .clk(clk), .rst(rst), .en(en), .period(period),
        .wr_en(wr_en), .wr_data(wr_data), .flush(flush), .clr_flags(clr_flags),
        .full(full), .empty(empty), .level(level), .data_o(data_o),
        .dac_en_o(dac_en_o), .renew_o(renew_o),
        .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue, the timer a plain integer
    typedef struct { int cyc; logic [15:0] d; } rel_t;
    rel_t        sb[$];
    logic [15:0] m_q[$];
    int          m_cnt = 0;
    int          cyc = 0;
    logic [15:0] m_data = 16'd0;
    bit          m_renew = 0, m_dacen = 0, m_under = 0, m_over = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            sb.delete();
            m_cnt = 0; m_data = 16'd0; m_renew = 0; m_dacen = 0;
            m_under = 0; m_over = 0;
        end else begin
            int  eff;
            bit  tick, was_full, was_empty, set_u, set_o;
            cyc++;
            eff       = (int'(period) < MINP) ? MINP : int'(period);
            was_full  = (m_q.size() == 16);
            was_empty = (m_q.size() == 0);
            tick      = en && !flush && (m_cnt >= eff - 1);
            set_u     = tick && was_empty;
            set_o     = !flush && wr_en && was_full;
            m_renew   = 0;
            if (flush) begin
                m_q.delete();
                m_cnt = 0;
            end else begin
                if (tick && !was_empty) begin
                    rel_t r;
                    m_data  = m_q.pop_front();
                    m_renew = 1;
                    r.cyc = cyc; r.d = m_data;
                    sb.push_back(r);
                end
                if (wr_en && !was_full) m_q.push_back(wr_data);
                m_cnt = (!en || tick) ? 0 : m_cnt + 1;
            end
            if (clr_flags) begin m_under = 0; m_over = 0; end
            if (set_u) m_under = 1;
            if (set_o) m_over = 1;
            m_dacen = en;
        end
    end

    // Monitor: compare state every cycle, pop the scoreboard on each release
    always @(posedge clk) begin
        #1;
        chk("level", 32'(level), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == 16));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("data_o", 32'(data_o), 32'(m_data));
        chk("dac_en_o", 32'(dac_en_o), 32'(m_dacen));
        chk("renew_o", 32'(renew_o), 32'(m_renew));
        chk("underrun", 32'(underrun), 32'(m_under));
        chk("overflow", 32'(overflow), 32'(m_over));
        if (renew_o) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_release", 32'd1, 32'd0);
            end else begin
                rel_t e;
                e = sb.pop_front();
                chk("sb_data", 32'(data_o), 32'(e.d));
                chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Stimulus helpers; all are entered and left just after a falling edge
    task automatic push(input logic [15:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_renew(input int lim, output int c);
        c = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (renew_o) begin c = cyc; break; end
        end
        if (c < 0) chk("renew_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_o"}, 32'(data_o), 32'd0);
        chk({tag, "_renew_o"}, 32'(renew_o), 32'd0);
        chk({tag, "_dac_en_o"}, 32'(dac_en_o), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    logic [15:0] vals[17];

    initial begin
        int t0, c;

        // Reset
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Basic stream
        push(16'h1234);
        push(16'hABCD);
        period = 16'd200; en = 1'b1; t0 = cyc;
        wait_renew(1000, c);
        chk("basic_t1", 32'(c - t0), 32'd200);
        chk("basic_d1", 32'(data_o), 32'h1234);
        chk("basic_lvl1", 32'(level), 32'd1);
        wait_renew(1000, c);
        chk("basic_t2", 32'(c - t0), 32'd400);
        chk("basic_d2", 32'(data_o), 32'hABCD);
        chk("basic_lvl2", 32'(level), 32'd0);

        // Clamp
        en = 1'b0;
        @(negedge clk);
        push(16'h5A5A);
        period = 16'd10; en = 1'b1; t0 = cyc;
        wait_renew(1000, c);
        chk("clamp_t", 32'(c - t0), 32'd128);
        chk("clamp_d", 32'(data_o), 32'h5A5A);

        // Underrun
        en = 1'b0;
        @(negedge clk);
        period = 16'd150; en = 1'b1;
        repeat (149) @(negedge clk);
        chk("under_early", 32'(underrun), 32'd0);
        @(negedge clk);
        chk("under_set", 32'(underrun), 32'd1);
        chk("under_no_renew", 32'(renew_o), 32'd0);
        chk("under_hold", 32'(data_o), 32'h5A5A);
        en = 1'b0; clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("under_clr", 32'(underrun), 32'd0);

        // Full / overflow, then a write on a tick while full
        for (int i = 0; i < 17; i++) begin
            vals[i] = 16'($urandom);
            push(vals[i]);
        end
        chk("full_flag", 32'(full), 32'd1);
        chk("full_level", 32'(level), 32'd16);
        chk("full_over", 32'(overflow), 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("full_over_clr", 32'(overflow), 32'd0);
        period = 16'd128; en = 1'b1;
        repeat (127) @(negedge clk);
        wr_en = 1'b1; wr_data = 16'hDEAD;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wp_renew", 32'(renew_o), 32'd1);
        chk("wp_level", 32'(level), 32'd15);
        chk("wp_over", 32'(overflow), 32'd1);
        chk("wp_data", 32'(data_o), 32'(vals[0]));
        for (int i = 1; i < 16; i++) begin
            wait_renew(300, c);
            chk("drain_order", 32'(data_o), 32'(vals[i]));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Flush mid-operation
        en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) push(16'($urandom));
        en = 1'b1; period = 16'd128;
        repeat (50) @(negedge clk);
        flush = 1'b1; t0 = cyc;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_data", 32'(data_o), 32'(vals[15]));
        push(16'h7777);
        wait_renew(400, c);
        chk("flush_restart_t", 32'(c - t0), 32'd129);
        chk("flush_restart_d", 32'(data_o), 32'h7777);

        // Asynchronous reset mid-period
        for (int i = 0; i < 3; i++) push(16'($urandom));
        repeat (60) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("arst");
        @(negedge clk);
        rst = 1'b0; t0 = cyc;
        push(16'h4242);
        wait_renew(400, c);
        chk("arst_t", 32'(c - t0), 32'd128);
        chk("arst_d", 32'(data_o), 32'h4242);

        // Randomized traffic with period changes, flushes and flag clears
        for (int i = 0; i < 3000; i++) begin
            wr_en     = ($urandom_range(0, 99) < 2);
            wr_data   = 16'($urandom);
            flush     = ($urandom_range(0, 999) == 0);
            clr_flags = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 399) == 0) en = ~en;
            if ($urandom_range(0, 299) == 0) period = 16'($urandom_range(0, 300));
            @(negedge clk);
        end
        wr_en = 1'b0; flush = 1'b0; clr_flags = 1'b0; en = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
